// File: rtl/gpr_wb_arb.sv
// Write-back arbiter for the GPR file write port: round-robin between execute (port 0)
// and load-return (port 1), registered write port, and a pending-write scoreboard.
module gpr_wb_arb #(
  parameter int WORD_WIDTH     = 32,
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int NUM_GPR        = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req0_valid,
  input  logic [GPR_ADDR_WIDTH-1:0] req0_addr,
  input  logic [WORD_WIDTH-1:0]     req0_data,
  output logic                      req0_ready,
  input  logic                      req1_valid,
  input  logic [GPR_ADDR_WIDTH-1:0] req1_addr,
  input  logic [WORD_WIDTH-1:0]     req1_data,
  output logic                      req1_ready,
  input  logic                      sb_set,
  input  logic [GPR_ADDR_WIDTH-1:0] sb_set_addr,
  input  logic                      flush,
  input  logic [GPR_ADDR_WIDTH-1:0] chk_addr_0,
  input  logic [GPR_ADDR_WIDTH-1:0] chk_addr_1,
  output logic                      busy_0,
  output logic                      busy_1,
  output logic                      gpr_we_,
  output logic [GPR_ADDR_WIDTH-1:0] gpr_wr_addr,
  output logic [WORD_WIDTH-1:0]     gpr_wr_data
);

  logic                      last_grant_q, last_grant_d;
  logic                      we_n_q, we_n_d;
  logic [GPR_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [WORD_WIDTH-1:0]     wr_data_q, wr_data_d;
  logic [NUM_GPR-1:0]        pending_q, pending_d;
  logic                      grant0, grant1, commit;

  // Arbitration: the port that did not win last time takes a contended cycle.
  always_comb begin
    grant0     = req0_valid & (~req1_valid | last_grant_q);
    grant1     = req1_valid & (~req0_valid | ~last_grant_q);
    req0_ready = grant0 & ~rst;
    req1_ready = grant1 & ~rst;
  end

  assign commit = ~we_n_q;

  always_comb begin
    last_grant_d = last_grant_q;
    we_n_d       = 1'b1;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    if (req0_ready) begin
      last_grant_d = 1'b0;
      if (req0_addr != '0) begin
        we_n_d    = 1'b0;
        wr_addr_d = req0_addr;
        wr_data_d = req0_data;
      end
    end else if (req1_ready) begin
      last_grant_d = 1'b1;
      if (req1_addr != '0) begin
        we_n_d    = 1'b0;
        wr_addr_d = req1_addr;
        wr_data_d = req1_data;
      end
    end
  end

  // Scoreboard: commit clears, flush clears all, then a new allocation is applied last.
  always_comb begin
    pending_d = pending_q;
    if (commit) pending_d[wr_addr_q] = 1'b0;
    if (flush) pending_d = '0;
    if (sb_set && (sb_set_addr != '0)) pending_d[sb_set_addr] = 1'b1;
  end

  // A same-cycle commit is forwarded by the register file, so it is not a hazard.
  always_comb begin
    busy_0 = pending_q[chk_addr_0] & ~(commit & (wr_addr_q == chk_addr_0))
             & (chk_addr_0 != '0) & ~rst;
    busy_1 = pending_q[chk_addr_1] & ~(commit & (wr_addr_q == chk_addr_1))
             & (chk_addr_1 != '0) & ~rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      we_n_q       <= 1'b1;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      pending_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      we_n_q       <= we_n_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      pending_q    <= pending_d;
    end
  end

  assign gpr_we_     = we_n_q;
  assign gpr_wr_addr = wr_addr_q;
  assign gpr_wr_data = wr_data_q;

endmodule

// File: tb/tb_gpr_wb_arb.sv
// Directed bench for gpr_wb_arb: arbitration order, write-port timing, scoreboard hazards.
module tb_gpr_wb_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [4:0]  req0_addr, req1_addr, sb_set_addr, chk_addr_0, chk_addr_1, gpr_wr_addr;
  logic [31:0] req0_data, req1_data, gpr_wr_data;
  logic        sb_set, flush, busy_0, busy_1, gpr_we_;
  int          checks = 0;
  int          errors = 0;

  gpr_wb_arb #(.WORD_WIDTH(32), .GPR_ADDR_WIDTH(5), .NUM_GPR(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .sb_set(sb_set), .sb_set_addr(sb_set_addr), .flush(flush),
    .chk_addr_0(chk_addr_0), .chk_addr_1(chk_addr_1), .busy_0(busy_0), .busy_1(busy_1),
    .gpr_we_(gpr_we_), .gpr_wr_addr(gpr_wr_addr), .gpr_wr_data(gpr_wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req0_valid = 0; req1_valid = 0; req0_addr = 0; req1_addr = 0;
    req0_data = 0; req1_data = 0; sb_set = 0; sb_set_addr = 0; flush = 0;
    chk_addr_0 = 0; chk_addr_1 = 0;

    // Reset: ready must stay low even with a valid request
    req0_valid = 1; req0_addr = 5'd3;
    tick();
    #1 chk("rst_ready0", req0_ready, 0);
    tick();
    rst = 0; req0_valid = 0; chk_addr_0 = 5'd1; chk_addr_1 = 5'd5;
    #1;
    chk("rst_we", gpr_we_, 1);
    chk("rst_addr", gpr_wr_addr, 0);
    chk("rst_data", gpr_wr_data, 0);
    chk("rst_busy0", busy_0, 0);
    chk("rst_busy1", busy_1, 0);
    chk("rst_ready0b", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);

    // Single write on port 0
    req0_valid = 1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    #1 chk("single_ready0", req0_ready, 1);
    chk("single_ready1", req1_ready, 0);
    tick();
    req0_valid = 0;
    chk("single_we", gpr_we_, 0);
    chk("single_addr", gpr_wr_addr, 5);
    chk("single_data", gpr_wr_data, 32'hDEADBEEF);
    tick();
    chk("single_we_n2", gpr_we_, 1);

    // Single write on port 1 leaves last_grant = 1
    req1_valid = 1; req1_addr = 5'd2; req1_data = 32'h11;
    #1 chk("p1_ready1", req1_ready, 1);
    tick();
    req1_valid = 0;
    chk("p1_addr", gpr_wr_addr, 2);
    chk("p1_we", gpr_we_, 0);
    tick();

    // Continuous contention: grants 0,1,0,1
    req0_valid = 1; req0_addr = 5'd3; req0_data = 32'hA0;
    req1_valid = 1; req1_addr = 5'd7; req1_data = 32'hB0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("cont_ready0", req0_ready, (i % 2 == 0));
      chk("cont_ready1", req1_ready, (i % 2 == 1));
      tick();
      chk("cont_we", gpr_we_, 0);
      chk("cont_addr", gpr_wr_addr, (i % 2 == 0) ? 32'd3 : 32'd7);
      chk("cont_data", gpr_wr_data, (i % 2 == 0) ? 32'hA0 : 32'hB0);
    end
    req0_valid = 0; req1_valid = 0;
    tick();

    // Scoreboard lifecycle
    sb_set = 1; sb_set_addr = 5'd9;
    tick();
    sb_set = 0; chk_addr_0 = 5'd9;
    #1 chk("sb_busy_set", busy_0, 1);
    req1_valid = 1; req1_addr = 5'd9; req1_data = 32'h99;
    tick();
    req1_valid = 0;
    chk("sb_commit_we", gpr_we_, 0);
    chk("sb_busy_commit", busy_0, 0);
    tick();
    chk("sb_busy_after", busy_0, 0);

    sb_set = 1; sb_set_addr = 5'd9;
    tick();
    sb_set = 0;
    chk("sb2_busy_set", busy_0, 1);
    req1_valid = 1;
    tick();
    req1_valid = 0; sb_set = 1; sb_set_addr = 5'd9;
    #1 chk("sb2_busy_commit", busy_0, 0);
    tick();
    sb_set = 0;
    chk("sb2_busy_kept", busy_0, 1);
    req0_valid = 1; req0_addr = 5'd9; req0_data = 32'h9A;
    tick();
    req0_valid = 0;
    tick();
    chk("sb2_busy_clear", busy_0, 0);

    // x0 handling
    sb_set = 1; sb_set_addr = 5'd0;
    tick();
    sb_set = 0; chk_addr_1 = 5'd0; chk_addr_0 = 5'd0;
    #1 chk("x0_busy1", busy_1, 0);
    chk("x0_busy0", busy_0, 0);
    req0_valid = 1; req0_addr = 5'd0; req0_data = 32'h55;
    #1 chk("x0_ready0", req0_ready, 1);
    tick();
    req0_valid = 0;
    chk("x0_we", gpr_we_, 1);
    chk("x0_addr_hold", gpr_wr_addr, 9);
    chk("x0_data_hold", gpr_wr_data, 32'h9A);

    // Flush with a committing write and a same-cycle allocation
    sb_set = 1; sb_set_addr = 5'd4; tick();
    sb_set_addr = 5'd6; tick();
    sb_set_addr = 5'd8; tick();
    sb_set_addr = 5'd10; tick();
    sb_set = 0;
    req0_valid = 1; req0_addr = 5'd4; req0_data = 32'h44;
    chk_addr_0 = 5'd4; chk_addr_1 = 5'd8;
    #1 chk("fl_busy4_pre", busy_0, 1);
    chk("fl_busy8_pre", busy_1, 1);
    tick();
    req0_valid = 0; flush = 1; sb_set = 1; sb_set_addr = 5'd6;
    chk("fl_commit_we", gpr_we_, 0);
    chk("fl_commit_addr", gpr_wr_addr, 4);
    tick();
    flush = 0; sb_set = 0; chk_addr_0 = 5'd6; chk_addr_1 = 5'd4;
    #1 chk("fl_busy6", busy_0, 1);
    chk("fl_busy4", busy_1, 0);
    chk_addr_1 = 5'd8;
    #1 chk("fl_busy8", busy_1, 0);
    chk_addr_1 = 5'd10;
    #1 chk("fl_busy10", busy_1, 0);

    // Reset mid-operation with a write waiting in the output register
    sb_set = 1; sb_set_addr = 5'd10;
    tick();
    sb_set = 0;
    req1_valid = 1; req1_addr = 5'd6; req1_data = 32'h66;
    tick();
    req1_valid = 0;
    chk("mr_we_pre", gpr_we_, 0);
    rst = 1;
    req0_valid = 1; req1_valid = 1;
    #1 chk("mr_busy10_rst", busy_1, 0);
    chk("mr_ready0_rst", req0_ready, 0);
    chk("mr_ready1_rst", req1_ready, 0);
    tick();
    rst = 0;
    #1;
    chk("mr_we", gpr_we_, 1);
    chk("mr_addr", gpr_wr_addr, 0);
    chk("mr_busy0", busy_0, 0);
    chk("mr_busy1", busy_1, 0);
    chk("mr_grant0_first", req0_ready, 1);
    chk("mr_grant1_first", req1_ready, 0);
    req0_valid = 0; req1_valid = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
